// File: rtl/keypad_pkg.sv
// Shared types and helpers for the keypad matrix scanner.
package keypad_pkg;

  // Event handshake FSM: IDLE waits for an unreported key change, SEND holds one event.
  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } evt_state_e;

  // Widest key matrix the popcount helper accepts (16x16).
  localparam int POP_MAX = 256;

  // Bits needed to index n items, never less than one.
  function automatic int code_width(input int n);
    if (n <= 1) return 1;
    return $clog2(n);
  endfunction

  // Number of set bits; callers zero-extend narrower vectors.
  function automatic int popcount(input logic [POP_MAX-1:0] v);
    int c;
    c = 0;
    for (int i = 0; i < POP_MAX; i++) begin
      if (v[i]) c++;
    end
    return c;
  endfunction

endpackage

// File: rtl/keypad_prio_enc.sv
// Lowest-set-bit priority encoder: returns the smallest set index and an any-set flag.
module keypad_prio_enc
  import keypad_pkg::*;
#(
  parameter int N     = 16,
  parameter int IDX_W = code_width(N)
) (
  input  logic [N-1:0]     vec,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  // Scan from the top down so the lowest set index is the last one written.
  always_comb begin
    idx = '0;
    any = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (vec[i]) begin
        idx = IDX_W'(i);
        any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/keypad_matrix_scanner.sv
// Key-matrix scanner: column strobing, row sampling, frame debounce and a
// lossless press/release event stream over valid/ready.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | no event pending; loads the lowest changed key when deb != acc
// SEND  | event presented; payload frozen until the consumer accepts it
module keypad_matrix_scanner
  import keypad_pkg::*;
#(
  parameter int  ROWS     = 4,
  parameter int  COLS     = 4,
  parameter int  SCAN_DIV = 1000,
  parameter int  DEBOUNCE = 4,
  localparam int CODE_W   = code_width(ROWS * COLS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic [ROWS-1:0]   row_in,
  output logic [COLS-1:0]   col_drv,
  output logic              evt_valid,
  input  logic              evt_ready,
  output logic [CODE_W-1:0] evt_code,
  output logic              evt_press,
  output logic              key_held,
  output logic              multi_key
);

  localparam int NKEYS  = ROWS * COLS;
  localparam int SLOT_W = $clog2(SCAN_DIV);
  localparam int COL_W  = code_width(COLS);
  localparam int STAB_W = $clog2(DEBOUNCE + 1);

  localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(SCAN_DIV - 1);
  localparam logic [COL_W-1:0]  COL_LAST  = COL_W'(COLS - 1);
  localparam logic [STAB_W-1:0] STAB_MAX  = STAB_W'(DEBOUNCE);

  logic [ROWS-1:0]   row_s1_q, row_s1_d;
  logic [ROWS-1:0]   row_s2_q, row_s2_d;
  logic [SLOT_W-1:0] slot_cnt_q, slot_cnt_d;
  logic [COL_W-1:0]  col_idx_q, col_idx_d;
  logic [COLS-1:0]   col_drv_q, col_drv_d;
  logic [NKEYS-1:0]  raw_q, raw_d;
  logic [NKEYS-1:0]  prev_q, prev_d;
  logic [NKEYS-1:0]  deb_q, deb_d;
  logic [NKEYS-1:0]  acc_q, acc_d;
  logic [STAB_W-1:0] stab_cnt_q, stab_cnt_d;
  logic              key_held_q, key_held_d;
  logic              multi_key_q, multi_key_d;
  evt_state_e        state_q, state_d;
  logic              evt_valid_q, evt_valid_d;
  logic [CODE_W-1:0] evt_code_q, evt_code_d;
  logic              evt_press_q, evt_press_d;

  logic              slot_end;
  logic              frame_done;
  logic [NKEYS-1:0]  diff;
  logic [CODE_W-1:0] diff_idx;
  logic              diff_any;
  int                pop_deb;

  // Keys not yet reported in their current debounced state.
  assign diff = deb_q ^ acc_q;

  keypad_prio_enc #(
    .N     (NKEYS),
    .IDX_W (CODE_W)
  ) u_prio_enc (
    .vec (diff),
    .idx (diff_idx),
    .any (diff_any)
  );

  // Row synchroniser, column scan timing and whole-frame debounce.
  always_comb begin
    row_s1_d   = row_in;
    row_s2_d   = row_s1_q;
    slot_cnt_d = slot_cnt_q;
    col_idx_d  = col_idx_q;
    col_drv_d  = '0;
    raw_d      = raw_q;
    prev_d     = prev_q;
    deb_d      = deb_q;
    stab_cnt_d = stab_cnt_q;
    slot_end   = 1'b0;
    frame_done = 1'b0;
    if (!en) begin
      slot_cnt_d = '0;
      col_idx_d  = '0;
      stab_cnt_d = '0;
    end else begin
      slot_end   = (slot_cnt_q == SLOT_LAST);
      frame_done = slot_end && (col_idx_q == COL_LAST);
      if (slot_end) begin
        slot_cnt_d = '0;
        raw_d[int'(col_idx_q) * ROWS +: ROWS] = row_s2_q;
        col_idx_d  = frame_done ? '0 : col_idx_q + 1'b1;
      end else begin
        slot_cnt_d = slot_cnt_q + 1'b1;
      end
      // Strobe follows the column index so the column is driven for the whole slot.
      col_drv_d = COLS'(1) << col_idx_d;
      if (frame_done) begin
        prev_d = raw_d;
        if (raw_d == prev_q) begin
          if (stab_cnt_q != STAB_MAX) stab_cnt_d = stab_cnt_q + 1'b1;
        end else begin
          stab_cnt_d = '0;
        end
        if ((raw_d == prev_q) && (stab_cnt_d == STAB_MAX)) deb_d = raw_d;
      end
    end
  end

  // Key-count flags follow the debounced matrix with one cycle of delay.
  always_comb begin
    pop_deb     = popcount(POP_MAX'(deb_q));
    key_held_d  = (pop_deb >= 1);
    multi_key_d = (pop_deb >= 2);
  end

  // Event FSM: one change at a time, lowest key index first, never dropped.
  always_comb begin
    state_d     = state_q;
    evt_valid_d = evt_valid_q;
    evt_code_d  = evt_code_q;
    evt_press_d = evt_press_q;
    acc_d       = acc_q;
    case (state_q)
      IDLE: begin
        if (diff_any) begin
          evt_code_d  = diff_idx;
          evt_press_d = deb_q[diff_idx];
          evt_valid_d = 1'b1;
          state_d     = SEND;
        end
      end
      SEND: begin
        // The reported state comes from the held payload, not from deb, so a
        // key that flipped again meanwhile produces a further event.
        if (evt_ready) begin
          acc_d[evt_code_q] = evt_press_q;
          evt_valid_d       = 1'b0;
          state_d           = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      row_s1_q    <= '0;
      row_s2_q    <= '0;
      slot_cnt_q  <= '0;
      col_idx_q   <= '0;
      col_drv_q   <= '0;
      raw_q       <= '0;
      prev_q      <= '0;
      deb_q       <= '0;
      acc_q       <= '0;
      stab_cnt_q  <= '0;
      key_held_q  <= 1'b0;
      multi_key_q <= 1'b0;
      state_q     <= IDLE;
      evt_valid_q <= 1'b0;
      evt_code_q  <= '0;
      evt_press_q <= 1'b0;
    end else begin
      row_s1_q    <= row_s1_d;
      row_s2_q    <= row_s2_d;
      slot_cnt_q  <= slot_cnt_d;
      col_idx_q   <= col_idx_d;
      col_drv_q   <= col_drv_d;
      raw_q       <= raw_d;
      prev_q      <= prev_d;
      deb_q       <= deb_d;
      acc_q       <= acc_d;
      stab_cnt_q  <= stab_cnt_d;
      key_held_q  <= key_held_d;
      multi_key_q <= multi_key_d;
      state_q     <= state_d;
      evt_valid_q <= evt_valid_d;
      evt_code_q  <= evt_code_d;
      evt_press_q <= evt_press_d;
    end
  end

  assign col_drv   = col_drv_q;
  assign evt_valid = evt_valid_q;
  assign evt_code  = evt_code_q;
  assign evt_press = evt_press_q;
  assign key_held  = key_held_q;
  assign multi_key = multi_key_q;

endmodule

// File: tb/tb_keypad_matrix_scanner.sv
// Scoreboard bench for keypad_matrix_scanner (4x4, 8 clk per slot, 2-frame debounce).
module tb_keypad_matrix_scanner;

  localparam int ROWS     = 4;
  localparam int COLS     = 4;
  localparam int SCAN_DIV = 8;
  localparam int DEBOUNCE = 2;
  localparam int NK       = ROWS * COLS;
  localparam int FRAME    = SCAN_DIV * COLS;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b0;
  logic       evt_ready = 1'b0;
  logic [3:0] row_in;
  logic [3:0] col_drv;
  logic       evt_valid;
  logic [3:0] evt_code;
  logic       evt_press;
  logic       key_held;
  logic       multi_key;

  // Physical key state: keys[c*ROWS + r] closes row r onto column c.
  logic [NK-1:0] keys = '0;

  int checks = 0;
  int fails = 0;
  int events_seen = 0;
  int ready_mode = 0;

  typedef struct {
    int code;
    bit press;
  } evt_t;
  evt_t exp_q[$];

  always #5 clk = ~clk;

  keypad_matrix_scanner #(
    .ROWS     (ROWS),
    .COLS     (COLS),
    .SCAN_DIV (SCAN_DIV),
    .DEBOUNCE (DEBOUNCE)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .row_in    (row_in),
    .col_drv   (col_drv),
    .evt_valid (evt_valid),
    .evt_ready (evt_ready),
    .evt_code  (evt_code),
    .evt_press (evt_press),
    .key_held  (key_held),
    .multi_key (multi_key)
  );

  // Ideal diode matrix: a row reads high when any driven column has a closed key on it.
  function automatic logic [3:0] rows_for(input logic [3:0] cd, input logic [NK-1:0] k);
    logic [3:0] r;
    r = '0;
    for (int c = 0; c < COLS; c++)
      for (int rr = 0; rr < ROWS; rr++)
        if (cd[c] && k[c * ROWS + rr]) r[rr] = 1'b1;
    return r;
  endfunction

  assign row_in = rows_for(col_drv, keys);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, required %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: every key whose state differs between two stable key sets
  // produces one event, reported in ascending key order.
  task automatic expect_change(input logic [NK-1:0] old_k, input logic [NK-1:0] new_k);
    evt_t e;
    for (int k = 0; k < NK; k++) begin
      if (old_k[k] != new_k[k]) begin
        e.code  = k;
        e.press = new_k[k];
        exp_q.push_back(e);
      end
    end
  endtask

  // Consumer readiness, updated just after each rising edge.
  always @(posedge clk) begin
    #1;
    case (ready_mode)
      0:       evt_ready = 1'b0;
      1:       evt_ready = 1'b1;
      default: evt_ready = 1'($urandom_range(0, 1));
    endcase
  end

  // Monitor: pops the scoreboard on every accepted event and checks payload stability while stalled.
  logic       hold_v = 1'b0;
  logic [3:0] hold_code = '0;
  logic       hold_press = 1'b0;
  always @(negedge clk) begin
    evt_t e;
    if (rst_n && evt_valid) begin
      if (hold_v) begin
        check("stall_code_stable", 32'(evt_code), 32'(hold_code));
        check("stall_press_stable", 32'(evt_press), 32'(hold_press));
      end
      if (evt_ready) begin
        events_seen++;
        if (exp_q.size() == 0) begin
          checks++;
          fails++;
          $display("FAIL unexpected_event: got code=%0d press=%0d, required no event (t=%0t)",
                   evt_code, evt_press, $time);
        end else begin
          e = exp_q.pop_front();
          check("evt_code", 32'(evt_code), 32'(e.code));
          check("evt_press", 32'(evt_press), 32'(e.press));
        end
        hold_v = 1'b0;
      end else begin
        hold_v     = 1'b1;
        hold_code  = evt_code;
        hold_press = evt_press;
      end
    end else begin
      hold_v = 1'b0;
    end
  end

  // Let debounce complete, then wait (bounded) for all expected events to drain.
  task automatic settle(input string name);
    int n;
    n = 0;
    repeat (6 * FRAME) @(negedge clk);
    while ((exp_q.size() != 0 || evt_valid) && n < 1000) begin
      @(negedge clk);
      n++;
    end
    check({name, "_drained"}, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic wait_valid(input string name, input int budget);
    int n;
    n = 0;
    while (!evt_valid && n < budget) begin
      @(negedge clk);
      n++;
    end
    check({name, "_valid_seen"}, 32'(evt_valid), 32'd1);
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0]    exp_cd;
    logic [NK-1:0] nk;
    int            n;
    int            seen0;
    int            k;

    // 1: reset state, then column strobe sequence
    rst_n = 1'b0;
    en    = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    check("rst_col_drv", 32'(col_drv), 32'd0);
    check("rst_evt_valid", 32'(evt_valid), 32'd0);
    check("rst_evt_code", 32'(evt_code), 32'd0);
    check("rst_evt_press", 32'(evt_press), 32'd0);
    check("rst_key_held", 32'(key_held), 32'd0);
    check("rst_multi_key", 32'(multi_key), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    en    = 1'b1;
    n = 0;
    while (col_drv !== 4'b0010 && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("col_drv_reach_col1", 32'(col_drv), 32'h2);
    for (int s = 0; s < 8; s++) begin
      exp_cd = 4'b0001 << ((s + 1) % 4);
      check("col_drv_slot_start", 32'(col_drv), 32'(exp_cd));
      repeat (SCAN_DIV - 1) @(negedge clk);
      check("col_drv_slot_end", 32'(col_drv), 32'(exp_cd));
      @(negedge clk);
    end
    check("idle_evt_valid", 32'(evt_valid), 32'd0);
    check("idle_key_held", 32'(key_held), 32'd0);

    // 2: press key 9 (row 1, column 2)
    ready_mode = 1;
    expect_change(keys, 16'h0200);
    keys = 16'h0200;
    wait_valid("press9_within_4_frames", 4 * FRAME);
    settle("press9");
    check("press9_key_held", 32'(key_held), 32'd1);
    check("press9_multi_key", 32'(multi_key), 32'd0);

    // 3: release key 9
    expect_change(keys, 16'h0000);
    keys = 16'h0000;
    settle("release9");
    check("release9_key_held", 32'(key_held), 32'd0);

    // 4: one-frame bounce must not produce an event
    seen0 = events_seen;
    keys[5] = 1'b1;
    repeat (20) @(negedge clk);
    keys[5] = 1'b0;
    settle("bounce");
    check("bounce_no_event", 32'(events_seen), 32'(seen0));
    check("bounce_key_held", 32'(key_held), 32'd0);

    // 5: two keys together while the consumer stalls
    ready_mode = 0;
    nk = keys;
    nk[3]  = 1'b1;
    nk[12] = 1'b1;
    expect_change(keys, nk);
    keys = nk;
    wait_valid("stall", 6 * FRAME);
    repeat (200) @(negedge clk);
    check("stall_valid", 32'(evt_valid), 32'd1);
    check("stall_code", 32'(evt_code), 32'd3);
    check("stall_press", 32'(evt_press), 32'd1);
    ready_mode = 1;
    settle("two_keys");
    check("two_keys_multi_key", 32'(multi_key), 32'd1);
    check("two_keys_key_held", 32'(key_held), 32'd1);

    // 6: reset while an event is pending, keys still down
    ready_mode = 0;
    keys[0] = 1'b1;
    wait_valid("pre_reset", 6 * FRAME);
    check("pre_reset_code", 32'(evt_code), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("reset_drops_valid", 32'(evt_valid), 32'd0);
    repeat (2) @(negedge clk);
    check("reset_key_held", 32'(key_held), 32'd0);
    check("reset_multi_key", 32'(multi_key), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    exp_q.delete();
    expect_change('0, keys);
    ready_mode = 2;
    settle("re_report");
    check("re_report_multi_key", 32'(multi_key), 32'd1);

    // Scan pause: strobes stop, a key closed meanwhile is picked up after resuming
    en = 1'b0;
    repeat (3) @(negedge clk);
    check("pause_col_drv", 32'(col_drv), 32'd0);
    nk = keys;
    nk[7] = 1'b1;
    expect_change(keys, nk);
    keys = nk;
    repeat (6 * FRAME) @(negedge clk);
    check("pause_col_drv_late", 32'(col_drv), 32'd0);
    check("pause_no_event", 32'(evt_valid), 32'd0);
    en = 1'b1;
    settle("resume");

    // Randomised key changes and bounces
    for (int it = 0; it < 30; it++) begin
      ready_mode = $urandom_range(1, 2);
      if ($urandom_range(0, 3) == 0) begin
        seen0 = events_seen;
        k = $urandom_range(0, NK - 1);
        keys[k] = ~keys[k];
        repeat ($urandom_range(4, 20)) @(negedge clk);
        keys[k] = ~keys[k];
        settle("rand_bounce");
        check("rand_bounce_no_event", 32'(events_seen), 32'(seen0));
      end else begin
        nk = keys;
        repeat ($urandom_range(1, 3)) begin
          k = $urandom_range(0, NK - 1);
          nk[k] = ~nk[k];
        end
        expect_change(keys, nk);
        keys = nk;
        settle("rand_change");
      end
      check("rand_key_held", 32'(key_held), 32'($countones(keys) >= 1));
      check("rand_multi_key", 32'(multi_key), 32'($countones(keys) >= 2));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
